// File: rtl/instruction_loader.sv
// instruction_loader: framed byte stream -> 32-bit big-endian words written to the instruction RAM.
// Define INSTRUCTION_LOADER_CHECKSUM_EN to require a trailing CHK byte (CHECK state + running sum).
module instruction_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd5;
`endif

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [1:0]  byte_cnt;
  logic [8:0]  word_cnt;
  logic [15:0] idle_cnt;
  logic        accept;
  logic        timed;
  logic        timeout;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]  acc;
  logic [7:0]  chk_sum;
`endif

  always_comb begin
    accept = in_valid && in_ready;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    timed   = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    chk_sum = acc + in_data;
`else
    timed   = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA);
`endif
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without an accepted byte.
    timeout = timed && !accept && (idle_cnt == 16'(TIMEOUT_CYCLES - 1));

    state_next = state;
    case (state)
      S_IDLE:  if (accept && (in_data == SYNC_BYTE)) state_next = S_ADDR;
      S_ADDR:  if (accept) state_next = S_COUNT;
      S_COUNT: if (accept) state_next = S_DATA;
      S_DATA:  if (accept && (byte_cnt == 2'd3)) state_next = S_WRITE;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_WRITE: state_next = (word_cnt == 9'd1) ? S_CHECK : S_DATA;
      S_CHECK: if (accept) state_next = S_IDLE;
`else
      S_WRITE: state_next = (word_cnt == 9'd1) ? S_IDLE : S_DATA;
`endif
      default: state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      word_cnt  <= 9'd0;
      idle_cnt  <= 16'd0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      acc       <= 8'd0;
`endif
    end else begin
      state    <= state_next;
      in_ready <= (state_next != S_WRITE);
      cpu_hold <= (state_next != S_IDLE);
      mem_we   <= (state_next == S_WRITE);
      done     <= 1'b0;

      if (accept || !timed) idle_cnt <= 16'd0;
      else                  idle_cnt <= idle_cnt + 16'd1;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      if (accept && (state != S_IDLE)) acc <= chk_sum;
`endif

      case (state)
        S_IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            error    <= 1'b0;
            byte_cnt <= 2'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            acc      <= 8'd0;
`endif
          end
        end
        S_ADDR: if (accept) mem_addr <= in_data;
        S_COUNT: begin
          if (accept) begin
            word_cnt <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            byte_cnt <= 2'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_wdata <= {mem_wdata[23:0], in_data};
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          mem_addr <= mem_addr + 8'd1;
          word_cnt <= word_cnt - 9'd1;
`ifndef INSTRUCTION_LOADER_CHECKSUM_EN
          if (word_cnt == 9'd1) done <= 1'b1;
`endif
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            if (chk_sum == 8'd0) done  <= 1'b1;
            else                 error <= 1'b1;
          end
        end
`endif
        default: ;
      endcase

      if (timeout) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: packet-level model (expected write queue) checked every cycle.
module tb_instruction_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  instruction_loader #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  pkt[$];
  logic [7:0]  pkt_chk;
  int          pkt_words;
  bit          pkt_ok;
  int          writes_seen = 0;
  int          done_seen = 0;
  int          nready_cnt = 0;
  logic [7:0]  last_addr = 8'd0;
  logic [31:0] last_data = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the expected write sequence.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) nready_cnt++;
      if (mem_we) begin
        logic [39:0] e;
        writes_seen++;
        last_addr = mem_addr;
        last_data = mem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
          check("write_data", mem_wdata, e[31:0]);
        end
        check("write_ready_low_hold_high", {30'd0, in_ready, cpu_hold}, 32'd1);
      end
      if (done) begin
        done_seen++;
        check("done_hold_err", {30'd0, cpu_hold, error}, 32'd0);
      end
    end
  end

  // Builds a packet and pushes the writes it must produce.
  task automatic build(input logic [7:0] addr, input logic [7:0] cnt, input logic [7:0] seed, input bit bad);
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] word;
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(addr);
    pkt.push_back(cnt);
    pkt_words = (cnt == 8'd0) ? 256 : int'(cnt);
    sum = addr + cnt;
    for (int w = 0; w < pkt_words; w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++) begin
        b = seed + 8'(w * 4 + k);
        pkt.push_back(b);
        word = {word[23:0], b};
        sum = sum + b;
      end
      exp_q.push_back({8'(int'(addr) + w), word});
    end
    pkt_chk = 8'd0 - sum + (bad ? 8'd1 : 8'd0);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    pkt.push_back(pkt_chk);
    pkt_ok = !bad;
`else
    pkt_ok = 1'b1;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic r;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    r = in_ready;
    while (!r) begin
      n++;
      if (n > 20) begin
        check("byte_accept_stall", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      r = in_ready;
    end
    @(posedge clk);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_from(input int lo);
    for (int i = lo; i < pkt.size(); i++) send_byte(pkt[i]);
    idle_bus();
  endtask

  // Waits for the packet to settle and compares packet-level outcome.
  task automatic finish_packet(input string name, input int w0, input int d0);
    repeat (3) @(negedge clk);
    check({name, "_writes"}, writes_seen - w0, pkt_words);
    check({name, "_done"}, done_seen - d0, {31'd0, pkt_ok});
    check({name, "_error"}, {31'd0, error}, {31'd0, !pkt_ok});
    check({name, "_hold_released"}, {31'd0, cpu_hold}, 32'd0);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    $display("packet %s: words=%0d writes=%0d done=%0d error=%0b", name, pkt_words,
             writes_seen - w0, done_seen - d0, error);
  endtask

  task automatic run_packet(input string name, input logic [7:0] addr, input logic [7:0] cnt,
                            input logic [7:0] seed, input bit bad);
    int w0, d0;
    w0 = writes_seen;
    d0 = done_seen;
    build(addr, cnt, seed, bad);
    send_from(0);
    finish_packet(name, w0, d0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, mem_we, cpu_hold, done, error, mem_addr}, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Basic one-word packet; pins the model with hand-computed values
    run_packet("basic", 8'h00, 8'h01, 8'h01, 1'b0);
    check("basic_chk_model", {24'd0, pkt_chk}, 32'h0000_00F5);
    check("basic_addr_literal", {24'd0, last_addr}, 32'h0000_0000);
    check("basic_data_literal", last_data, 32'h0102_0304);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    run_packet("bad_chk", 8'h00, 8'h01, 8'h01, 1'b1);
    check("bad_chk_model", {24'd0, pkt_chk}, 32'h0000_00F6);
`endif

    // Address wrap with stall count
    nready_cnt = 0;
    run_packet("wrap", 8'hFE, 8'h03, 8'h40, 1'b0);
    check("wrap_ready_low_cycles", nready_cnt, 32'd3);
    check("wrap_last_addr", {24'd0, last_addr}, 32'h0000_0000);

    // Leading junk then a packet
    send_byte(8'h00);
    send_byte(8'h11);
    run_packet("junk", 8'h30, 8'h02, 8'h80, 1'b0);

    // COUNT=0 means 256 words
    nready_cnt = 0;
    run_packet("count0", 8'h00, 8'h00, 8'h10, 1'b0);
    check("count0_ready_low_cycles", nready_cnt, 32'd256);
    check("count0_last_addr", {24'd0, last_addr}, 32'h0000_00FF);

    // Timeout mid-DATA
    w0 = writes_seen;
    d0 = done_seen;
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    idle_bus();
    repeat (TO - 3) @(negedge clk);
    check("timeout_not_early", {30'd0, error, cpu_hold}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = error;
    end
    check("timeout_error", {31'd0, seen}, 32'd1);
    check("timeout_hold", {31'd0, cpu_hold}, 32'd0);
    check("timeout_no_write_done", (writes_seen - w0) + (done_seen - d0), 32'd0);
    $display("packet timeout: error=%0b cpu_hold=%0b", error, cpu_hold);

    // Sync clears sticky error, then the packet completes
    w0 = writes_seen;
    d0 = done_seen;
    build(8'h50, 8'h01, 8'h20, 1'b0);
    send_byte(pkt[0]);
    idle_bus();
    check("sync_clears_error", {30'd0, error, cpu_hold}, 32'd1);
    send_from(1);
    finish_packet("after_timeout", w0, d0);

    // Asynchronous reset mid-DATA
    build(8'h20, 8'h02, 8'h55, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) send_byte(pkt[i]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_reset_outputs", {in_ready, mem_we, cpu_hold, done, error, mem_addr}, 32'd0);
    check("async_reset_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", {29'd0, in_ready, cpu_hold, error}, 32'd4);
    $display("packet reset_abort: outputs cleared");
    run_packet("after_reset", 8'h20, 8'h02, 8'h55, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
